// File: rtl/if_id_skid_if.sv
// rtl/if_id_skid_if.sv - fetch/decode handshake bundle for the IF/ID skid buffer
//
// Purpose: carries every non-clock, non-reset signal between fetch, the
// IF/ID buffer and decode.
// Modports:
//   slave  - the buffer: takes fetch data, ValidF, FlushD and ReadyD;
//            drives ReadyF, the head outputs, ValidD and Count
//   master - the surrounding pipeline (or a bench) driving the buffer
interface if_id_skid_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PCPlus4F;
  logic                  ValidF;
  logic                  ReadyF;
  logic                  FlushD;
  logic                  ReadyD;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;
  logic [1:0]            Count;

  modport slave (
    input  InstrF, PCF, PCPlus4F, ValidF, FlushD, ReadyD,
    output ReadyF, InstrD, PCD, PCPlus4D, ValidD, Count
  );

  modport master (
    output InstrF, PCF, PCPlus4F, ValidF, FlushD, ReadyD,
    input  ReadyF, InstrD, PCD, PCPlus4D, ValidD, Count
  );
endinterface

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - 2-entry in-order IF/ID skid buffer with flush
//
// Purpose: decouples fetch from decode. Entry 0 is the head and drives the
// decode-side outputs straight from registers; entry 1 absorbs one extra
// instruction when decode stalls. An empty buffer presents a NOP bubble.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset, overrides flush/push/pop
//   bus  - if_id_skid_if.slave: InstrF/PCF/PCPlus4F/ValidF/ReadyF from fetch,
//          FlushD, ReadyD/InstrD/PCD/PCPlus4D/ValidD to decode, Count
module if_id_skid #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic         clk,
  input  logic         rst,
  if_id_skid_if.slave  bus
);

  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] instr0;
  logic [DATA_WIDTH-1:0] pc0;
  logic [DATA_WIDTH-1:0] pc4_0;
  logic [DATA_WIDTH-1:0] instr1;
  logic [DATA_WIDTH-1:0] pc1;
  logic [DATA_WIDTH-1:0] pc4_1;

  logic       ready_f;
  logic       valid_d;
  logic       push;
  logic       pop;
  logic [2:0] count_sum;

  // ReadyF depends only on registered occupancy and rst, so decode stalls
  // and redirects never form a combinational loop back into fetch.
  assign ready_f = (count != 2'd2) & ~rst;
  assign valid_d = (count != 2'd0);
  assign push    = bus.ValidF & ready_f;
  assign pop     = valid_d & bus.ReadyD;

  // Three bits wide so an underflow wraps to 7 and an overflow reaches 3,
  // both of which the occupancy check below rejects.
  assign count_sum = {1'b0, count} + {2'b00, push} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (rst || bus.FlushD) begin
      count  <= 2'd0;
      instr0 <= NOP_INSTR;
      pc0    <= '0;
      pc4_0  <= '0;
      instr1 <= '0;
      pc1    <= '0;
      pc4_1  <= '0;
    end else begin
      count <= count_sum[1:0];
      if (pop && count == 2'd2) begin
        // Full buffer drains: entry 1 shifts up. Push cannot coincide here.
        instr0 <= instr1;
        pc0    <= pc1;
        pc4_0  <= pc4_1;
        instr1 <= '0;
        pc1    <= '0;
        pc4_1  <= '0;
      end else if (push && (count == 2'd0 || pop)) begin
        // Empty, or single entry replaced in the same cycle: new head.
        instr0 <= bus.InstrF;
        pc0    <= bus.PCF;
        pc4_0  <= bus.PCPlus4F;
      end else if (push) begin
        instr1 <= bus.InstrF;
        pc1    <= bus.PCF;
        pc4_1  <= bus.PCPlus4F;
      end else if (pop) begin
        // Last entry leaves: head reverts to the bubble.
        instr0 <= NOP_INSTR;
        pc0    <= '0;
        pc4_0  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.FlushD) begin
      assert (count_sum <= 3'd2);
    end
  end

  assign bus.ReadyF   = ready_f;
  assign bus.ValidD   = valid_d;
  assign bus.Count    = count;
  assign bus.InstrD   = instr0;
  assign bus.PCD      = pc0;
  assign bus.PCPlus4D = pc4_0;

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - scoreboard bench for if_id_skid
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_id_skid_if #(.DATA_WIDTH(32)) bus ();

  if_id_skid #(.DATA_WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int     vectors     = 0;
  int     miscompares = 0;
  entry_t model_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on the falling edge compare the DUT against the queue model,
  // then advance the model by what the coming rising edge will do.
  always @(negedge clk) begin
    int     sz;
    bit     do_pop;
    bit     do_push;
    entry_t e;
    sz = model_q.size();
    check("Count",  {30'd0, bus.Count}, sz);
    check("ReadyF", {31'd0, bus.ReadyF}, {31'd0, (sz < 2) && !rst});
    check("ValidD", {31'd0, bus.ValidD}, {31'd0, sz != 0});
    if (sz != 0) begin
      check("InstrD",   bus.InstrD,   model_q[0].instr);
      check("PCD",      bus.PCD,      model_q[0].pc);
      check("PCPlus4D", bus.PCPlus4D, model_q[0].pc4);
    end else begin
      check("InstrD_bubble",   bus.InstrD,   NOP);
      check("PCD_bubble",      bus.PCD,      32'd0);
      check("PCPlus4D_bubble", bus.PCPlus4D, 32'd0);
    end
    if (rst || bus.FlushD) begin
      model_q.delete();
    end else begin
      do_pop  = (sz != 0) && bus.ReadyD;
      do_push = bus.ValidF && (sz < 2);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.instr = bus.InstrF;
        e.pc    = bus.PCF;
        e.pc4   = bus.PCPlus4F;
        model_q.push_back(e);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] instr, input logic rd, input logic fl);
    rst          = r;
    bus.ValidF   = v;
    bus.PCF      = pc;
    bus.PCPlus4F = pc + 32'd4;
    bus.InstrF   = instr;
    bus.ReadyD   = rd;
    bus.FlushD   = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc_ctr;
    bus.ValidF   = 1'b0;
    bus.PCF      = '0;
    bus.PCPlus4F = '0;
    bus.InstrF   = '0;
    bus.ReadyD   = 1'b0;
    bus.FlushD   = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 32'h40, 32'hdeadbeef, 1, 0);

    // Reset release, then single push with ReadyD high, then drain.
    step(0, 1, 32'h00, 32'h00500093, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);

    // Stall: fill to two, hold, pop once.
    step(0, 1, 32'h00, 32'h00100113, 0, 0);
    step(0, 1, 32'h04, 32'h00200193, 0, 0);
    step(0, 1, 32'h50, 32'h11111111, 0, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);

    // Simultaneous push and pop at Count=1.
    step(0, 1, 32'h08, 32'h00300213, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);

    // Fill, then flush with a same-cycle fetch.
    step(0, 1, 32'h0c, 32'h00400293, 0, 0);
    step(0, 1, 32'h10, 32'h00500313, 0, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0);

    // Reset while full, then release.
    step(0, 1, 32'h14, 32'h00600393, 0, 0);
    step(0, 1, 32'h18, 32'h00700413, 0, 0);
    step(1, 1, 32'h1c, 32'h00800493, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0);

    // Randomized traffic.
    pc_ctr = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      logic v;
      logic rd;
      logic fl;
      logic r;
      v  = $urandom_range(0, 1);
      rd = $urandom_range(0, 1);
      fl = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, v, pc_ctr, $urandom, rd, fl);
      pc_ctr = pc_ctr + 32'd4;
    end

    step(0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of instruction and PC paths.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble value.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port InstrF  input  DATA_WIDTH  instruction from the fetch stage.
REQ-006 SHALL have port PCF  input  DATA_WIDTH  PC of InstrF.
REQ-007 SHALL have port PCPlus4F  input  DATA_WIDTH  PCF+4 from fetch.
REQ-008 SHALL have port ValidF  input  1  fetch presents a valid instruction.
REQ-009 SHALL have port ReadyF  output  1  buffer can accept; fetch holds its PC when low.
REQ-010 SHALL have port FlushD  input  1  discard all buffered and incoming entries (driven by PCSrcE).
REQ-011 SHALL have port ReadyD  input  1  decode consumes the head entry this cycle.
REQ-012 SHALL have port InstrD  output  DATA_WIDTH  head instruction.
REQ-013 SHALL have port PCD  output  DATA_WIDTH  head PC.
REQ-014 SHALL have port PCPlus4D  output  DATA_WIDTH  head PC+4.
REQ-015 SHALL have port ValidD  output  1  head entry valid.
REQ-016 SHALL have port Count  output  2  occupancy, 0..2.

Function
REQ-017 SHALL be a 2-entry in-order buffer; entry 0 (head) drives InstrD/PCD/PCPlus4D directly from registers.
REQ-018 SHALL define push = ValidF & ReadyF and pop = ValidD & ReadyD.
REQ-019 SHALL drive ReadyF = (Count != 2) & ~rst, derived from registered state only; no combinational path from ReadyD or FlushD to ReadyF.
REQ-020 SHALL drive ValidD = (Count != 0), from registered state.
REQ-021 SHALL have latency 1: a push into an empty buffer appears at the head on the next cycle.
REQ-022 SHALL handle Count=0, push: next Count=1, head = pushed entry.
REQ-023 SHALL handle Count=1, push and no pop: next Count=2, entry 1 = pushed entry, head unchanged.
REQ-024 SHALL handle Count=1, push and pop: next Count=1, head = pushed entry.
REQ-025 SHALL handle Count=1, pop only: next Count=0.
REQ-026 SHALL handle Count=2, pop: next Count=1, head = entry 1; no push is possible because ReadyF=0.
REQ-027 SHALL hold head outputs stable while ValidD=1 and ReadyD=0.
REQ-028 SHALL, on FlushD=1 at a rising edge, set next Count=0 regardless of push/pop; flush has priority over both, and the same-cycle InstrF is discarded.
REQ-029 SHALL, whenever Count=0, drive InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
REQ-030 SHALL ignore ReadyD when ValidD=0 and ignore InstrF/PCF/PCPlus4F when push=0.
REQ-031 SHALL never pass Count beyond 2 or below 0; an occupancy update that would violate this is a design error flagged by an assertion.

Reset
REQ-032 SHALL, while rst=1 at a rising edge, set Count=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, clear entry 1, and hold ReadyF=0.
REQ-033 SHALL give rst priority over FlushD, push and pop; reset mid-stream discards all entries.
REQ-034 SHALL drive ReadyF=1 in the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover this case: reset, then push PCF=0x00 with InstrF=0x00500093 and ReadyD=1 -> next cycle ValidD=1, PCD=0x00, InstrD=0x00500093, Count=1.
REQ-036 SHALL cover this case: ReadyD=0, push PCF 0x00 and 0x04 -> Count=2, ReadyF=0, head PCD=0x00 held; then ReadyD=1 for 1 cycle -> PCD=0x04, Count=1, ReadyF=1.
REQ-037 SHALL cover this case: Count=1 with push and pop in the same cycle (PCF=0x08) -> Count stays 1, PCD=0x08.
REQ-038 SHALL cover this case: Count=2 with FlushD=1 and ValidF=1 in the same cycle -> next Count=0, ValidD=0, InstrD=0x00000013, PCD=0.
REQ-039 SHALL cover this case: rst=1 asserted with Count=2 -> next cycle Count=0, ReadyF=0; after rst=0 -> ReadyF=1.
REQ-040 SHALL cover this case: random ValidF/ReadyD/FlushD for 10k cycles against a queue model -> popped PC sequence matches pushed sequence minus flushed entries, and Count stays within 0..2.
